mem_stage_lsu: RTL and testbench

Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs and drives a req/gnt/rvalid data-memory bus. It stalls the pipeline while an access is outstanding, resolves branches, and registers results into the MEM/WB stage outputs. It sits between the EX/MEM register and writeback.

---
 rtl/mem_stage_lsu_if.sv | 15 +
 rtl/mem_stage_lsu.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and the memory (slave).
// req/gnt address handshake followed by an rvalid data beat for reads.
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives the data bus, stalls the pipeline while an
// access is outstanding, resolves branches and registers results into MEM/WB.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_rs2,
  input  logic [31:0] mem_branch_target,
  input  logic [4:0]  mem_rd,
  input  logic [2:0]  mem_funct3,
  input  logic        mem_zero,
  input  logic        mem_branch,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_memtoreg,
  input  logic        mem_regwrite,
  mem_stage_lsu_if.master dmem,
  output logic        mem_stall,
  output logic        pc_src,
  output logic [31:0] pc_branch_target,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_load_data,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_GNT   = 2'd1,
    S_WAIT_RDATA = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        op_c, we_c, mis_c, req_c, done_c, tmo_c, uns_c;
  logic [1:0]  size_c, off_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_c;
  logic [15:0] half_c;
  logic [7:0]  byte_c;

  // Access decode: size from funct3[1:0], signedness from funct3[2]
  always_comb begin
    op_c   = mem_read | mem_write;
    we_c   = mem_write & ~mem_read;
    size_c = mem_funct3[1:0];
    uns_c  = mem_funct3[2];
    off_c  = mem_alu_out[1:0];
    mis_c  = op_c & (((size_c == 2'b01) & off_c[0]) |
                     ((size_c == 2'b10) & (off_c != 2'b00)));
    case (size_c)
      2'b00: begin
        be_c    = 4'b0001 << off_c;
        wdata_c = {4{mem_rs2[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << off_c;
        wdata_c = {2{mem_rs2[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = mem_rs2;
      end
    endcase
  end

  // Load lane select and extension
  always_comb begin
    half_c = off_c[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    byte_c = off_c[0] ? half_c[15:8] : half_c[7:0];
    case (size_c)
      2'b00:   load_c = {{24{byte_c[7] & ~uns_c}}, byte_c};
      2'b01:   load_c = {{16{half_c[15] & ~uns_c}}, half_c};
      default: load_c = dmem.rdata;
    endcase
  end

  // Bus FSM next-state, completion and timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_c   = 1'b0;
    done_c  = 1'b0;
    tmo_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_c = op_c & ~mis_c;
        if (req_c & dmem.gnt) begin
          if (we_c) done_c = 1'b1;
          else      state_d = S_WAIT_RDATA;
        end else if (req_c) begin
          state_d = S_WAIT_GNT;
        end
      end
      S_WAIT_GNT: begin
        req_c = 1'b1;
        if (dmem.gnt) begin
          if (we_c) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_RDATA;
          end
        end else if (cnt_q == CNT_LAST) begin
          done_c  = 1'b1;
          tmo_c   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_RDATA: begin
        if (dmem.rvalid) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done_c  = 1'b1;
          tmo_c   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Request and stall are gated by reset so they drop without waiting for an edge
  assign dmem.req   = req_c & ~rst;
  assign dmem.we    = we_c;
  assign dmem.addr  = {mem_alu_out[31:2], 2'b00};
  assign dmem.wdata = wdata_c;
  assign dmem.be    = be_c;

  assign mem_stall        = op_c & ~mis_c & ~done_c & ~rst;
  assign pc_src           = mem_branch & mem_zero;
  assign pc_branch_target = mem_branch_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register: capture on a non-stalled cycle, bubble otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_alu_out   <= '0;
      wb_load_data <= '0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else if (!mem_stall) begin
      wb_alu_out   <= mem_alu_out;
      wb_load_data <= load_c;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite & ~mis_c & ~tmo_c;
      wb_memtoreg  <= mem_memtoreg;
      misalign_err <= mis_c;
      bus_err      <= tmo_c;
    end else begin
      wb_regwrite  <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a reactive bus responder plus a scoreboard
// of expected MEM/WB results, then a reset-during-transaction scenario.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic [31:0] mem_alu_out, mem_rs2, mem_branch_target;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic        mem_zero, mem_branch, mem_read, mem_write, mem_memtoreg, mem_regwrite;
  logic        mem_stall, pc_src;
  logic [31:0] pc_branch_target, wb_alu_out, wb_load_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, wb_memtoreg, misalign_err, bus_err;

  mem_stage_lsu_if dmem ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(255)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_alu_out       (mem_alu_out),
    .mem_rs2           (mem_rs2),
    .mem_branch_target (mem_branch_target),
    .mem_rd            (mem_rd),
    .mem_funct3        (mem_funct3),
    .mem_zero          (mem_zero),
    .mem_branch        (mem_branch),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_memtoreg      (mem_memtoreg),
    .mem_regwrite      (mem_regwrite),
    .dmem              (dmem),
    .mem_stall         (mem_stall),
    .pc_src            (pc_src),
    .pc_branch_target  (pc_branch_target),
    .wb_alu_out        (wb_alu_out),
    .wb_load_data      (wb_load_data),
    .wb_rd             (wb_rd),
    .wb_regwrite       (wb_regwrite),
    .wb_memtoreg       (wb_memtoreg),
    .misalign_err      (misalign_err),
    .bus_err           (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rd_en;
    logic        wr_en;
    logic        rw;
    logic        m2r;
    logic [31:0] rdata;
    int          gnt_dly;   // cycles of req before gnt; <0 = never
    int          rv_dly;    // cycles after grant before rvalid; <0 = never
    logic        stray;     // drive stray gnt/rvalid the LSU must ignore
  } op_t;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        mis;
    logic        berr;
    logic        chk_ld;
    logic [31:0] ld;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_mis(input op_t o);
    logic isop;
    isop = o.rd_en | o.wr_en;
    return isop & (((o.f3 == 3'b001 || o.f3 == 3'b101) && o.addr[0]) ||
                   (o.f3 == 3'b010 && o.addr[1:0] != 2'b00));
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] b;
    if (f3[1:0] == 2'b00)      b = 4'b0001 << off;
    else if (f3[1:0] == 2'b01) b = 4'b0011 << off;
    else                       b = 4'b1111;
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [1:0] off,
                                       input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> (8 * off);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic op_t mk(input logic [31:0] addr, input logic [31:0] rs2,
                             input logic [4:0] rd, input logic [2:0] f3,
                             input logic rd_en, input logic wr_en, input logic rw,
                             input logic m2r, input logic [31:0] rdata,
                             input int gnt_dly, input int rv_dly, input logic stray);
    op_t o;
    o.addr = addr; o.rs2 = rs2; o.rd = rd; o.f3 = f3;
    o.rd_en = rd_en; o.wr_en = wr_en; o.rw = rw; o.m2r = m2r;
    o.rdata = rdata; o.gnt_dly = gnt_dly; o.rv_dly = rv_dly; o.stray = stray;
    return o;
  endfunction

  // Present one EX/MEM entry (called just after a posedge), answer the bus, then
  // compare MEM/WB on the edge that ends the stall
  task automatic run_op(input string name, input op_t o, input int exp_stalls);
    exp_t e;
    logic isop, mis, gnt_seen, done, gnt_now, req_now;
    int   waited, rv_cnt, stalls;
    mem_alu_out  = o.addr;  mem_rs2     = o.rs2;  mem_rd      = o.rd;
    mem_funct3   = o.f3;    mem_read    = o.rd_en; mem_write  = o.wr_en;
    mem_regwrite = o.rw;    mem_memtoreg = o.m2r; dmem.rdata  = o.rdata;
    isop   = o.rd_en | o.wr_en;
    mis    = m_mis(o);
    e.alu  = o.addr;
    e.rd   = o.rd;
    e.m2r  = o.m2r;
    e.mis  = mis;
    e.berr = isop & ~mis & ((o.gnt_dly < 0) | (o.rd_en & (o.rv_dly < 0)));
    e.rw   = o.rw & ~mis & ~e.berr;
    e.chk_ld = o.rd_en & ~mis & ~e.berr;
    e.ld   = m_ld(o.f3, o.addr[1:0], o.rdata);
    sb_q.push_back(e);

    gnt_seen = 1'b0; done = 1'b0; waited = 0; rv_cnt = 0; stalls = 0;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      dmem.gnt = 1'b0;
      dmem.rvalid = 1'b0;
      #1;
      if (o.gnt_dly >= 0 && !gnt_seen && dmem.req && waited >= o.gnt_dly) dmem.gnt = 1'b1;
      if (gnt_seen && o.rv_dly >= 0 && rv_cnt >= o.rv_dly) dmem.rvalid = 1'b1;
      if (o.stray && !gnt_seen) begin
        dmem.rvalid = 1'b1;
        if (!dmem.req) dmem.gnt = 1'b1;
      end
      #1;
      if (cyc == 0) begin
        check_eq({name, "_req"}, 32'(dmem.req), 32'(isop & ~mis));
        if (isop & ~mis) begin
          check_eq({name, "_addr"}, dmem.addr, {o.addr[31:2], 2'b00});
          check_eq({name, "_we"}, 32'(dmem.we), 32'(o.wr_en & ~o.rd_en));
          check_eq({name, "_be"}, 32'(dmem.be), 32'(m_be(o.f3, o.addr[1:0])));
          if (o.wr_en & ~o.rd_en)
            check_eq({name, "_wdata"}, dmem.wdata, m_wdata(o.f3, o.rs2));
        end
      end
      req_now = dmem.req;
      gnt_now = dmem.gnt & dmem.req;
      if (mem_stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      if (gnt_now) begin
        gnt_seen = 1'b1;
        rv_cnt = 1;
      end else if (gnt_seen) begin
        rv_cnt++;
      end
      if (req_now && !gnt_now) waited++;
      if (!done && stalls <= 4) check_eq({name, "_bubble_rw"}, 32'(wb_regwrite), 32'h0);
    end
    check_eq({name, "_done"}, 32'(done), 32'h1);
    check_eq({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    e = sb_q.pop_front();
    check_eq({name, "_wb_alu"}, wb_alu_out, e.alu);
    check_eq({name, "_wb_rd"}, 32'(wb_rd), 32'(e.rd));
    check_eq({name, "_wb_rw"}, 32'(wb_regwrite), 32'(e.rw));
    check_eq({name, "_wb_m2r"}, 32'(wb_memtoreg), 32'(e.m2r));
    check_eq({name, "_mis"}, 32'(misalign_err), 32'(e.mis));
    check_eq({name, "_berr"}, 32'(bus_err), 32'(e.berr));
    if (e.chk_ld) check_eq({name, "_ld"}, wb_load_data, e.ld);
  endtask

  op_t nop;

  initial begin
    rst = 1'b1;
    mem_alu_out = '0; mem_rs2 = '0; mem_branch_target = '0; mem_rd = '0;
    mem_funct3 = '0; mem_zero = 1'b0; mem_branch = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; mem_memtoreg = 1'b0; mem_regwrite = 1'b0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    nop = mk(32'h0, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0);

    #2;
    check_eq("rst_wb_alu", wb_alu_out, 32'h0);
    check_eq("rst_wb_rw", 32'(wb_regwrite), 32'h0);
    check_eq("rst_errs", 32'({misalign_err, bus_err}), 32'h0);
    check_eq("rst_req", 32'(dmem.req), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Branch resolves combinationally in the same cycle
    mem_branch = 1'b1; mem_zero = 1'b1; mem_branch_target = 32'h40;
    #1;
    check_eq("br_pc_src", 32'(pc_src), 32'h1);
    check_eq("br_target", pc_branch_target, 32'h40);
    mem_zero = 1'b0;
    #1;
    check_eq("br_not_taken", 32'(pc_src), 32'h0);
    mem_branch = 1'b0;

    run_op("alu", mk(32'h1234, 32'h0, 5'd5, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0, 1'b1), 0);
    run_op("sb", mk(32'h1003, 32'hAB, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0), 0);
    run_op("lb", mk(32'h2002, 32'h0, 5'd7, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0080FF00, 2, 3, 1'b0), 5);
    run_op("lhu", mk(32'h2002, 32'h0, 5'd8, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80FF1234, 0, 2, 1'b1), 2);
    run_op("lw_mis", mk(32'h2001, 32'h0, 5'd9, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 0, 0, 1'b0), 0);
    run_op("nop1", nop, 0);
    run_op("sh", mk(32'h3002, 32'h1234BEEF, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3, 0, 1'b0), 3);
    run_op("lw", mk(32'h4000, 32'h0, 5'd10, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 0, 1, 1'b0), 1);
    run_op("lbu_rw", mk(32'h4001, 32'h55, 5'd11, 3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12F0AB00, 1, 1, 1'b0), 2);
    run_op("lh", mk(32'h4000, 32'h0, 5'd12, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000F00D, 0, 1, 1'b0), 1);
    run_op("sw", mk(32'h5000, 32'hDEADBEEF, 5'd0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0), 0);
    run_op("lw_tmo", mk(32'h6000, 32'h0, 5'd13, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 0, -1, 1'b0), 255);
    run_op("nop2", nop, 0);

    // Reset while a read is stuck waiting for grant
    mem_alu_out = 32'h7000; mem_funct3 = 3'b010; mem_read = 1'b1; mem_write = 1'b0;
    mem_regwrite = 1'b1; mem_rd = 5'd14;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_req", 32'(dmem.req), 32'h1);
    check_eq("pre_rst_stall", 32'(mem_stall), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_req", 32'(dmem.req), 32'h0);
    check_eq("rst_mid_stall", 32'(mem_stall), 32'h0);
    check_eq("rst_mid_wb_rw", 32'(wb_regwrite), 32'h0);
    mem_read = 1'b0; mem_regwrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("post_rst", mk(32'h99, 32'h0, 5'd3, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0, 1'b0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
